// File: rtl/conv3x3_relu_if.sv
// ---------------------------------------------------------------------------
// conv3x3_relu_if
// Bundles every non-clock signal of conv3x3_relu: the 3x3 window stream from
// the window generator, the coefficient load channel, status flags and the
// delayed result stream.
//   slave  : the convolution block (consumes windows/coefficients, drives results)
//   master : the environment (window generator, coefficient loader, result sink)
// Signals:
//   matrix_vsync/href/h_cnt/v_cnt, data_combination : window stream in
//   w_load_start/valid/data, w_load_ready             : coefficient load channel
//   coef_loaded, frame_drop                           : status
//   conv_vsync/href/h_cnt/v_cnt, conv_data            : result stream out
// ---------------------------------------------------------------------------
interface conv3x3_relu_if #(
  parameter int DATA_WIDTH = 16
);
  logic                      matrix_vsync;
  logic                      matrix_href;
  logic [6:0]                matrix_h_cnt;
  logic [6:0]                matrix_v_cnt;
  logic [9*DATA_WIDTH-1:0]   data_combination;
  logic                      w_load_start;
  logic                      w_load_valid;
  logic [DATA_WIDTH-1:0]     w_load_data;
  logic                      w_load_ready;
  logic                      coef_loaded;
  logic                      frame_drop;
  logic                      conv_vsync;
  logic                      conv_href;
  logic [6:0]                conv_h_cnt;
  logic [6:0]                conv_v_cnt;
  logic [DATA_WIDTH-1:0]     conv_data;

  modport master (
    output matrix_vsync, matrix_href, matrix_h_cnt, matrix_v_cnt, data_combination,
    output w_load_start, w_load_valid, w_load_data,
    input  w_load_ready, coef_loaded, frame_drop,
    input  conv_vsync, conv_href, conv_h_cnt, conv_v_cnt, conv_data
  );

  modport slave (
    input  matrix_vsync, matrix_href, matrix_h_cnt, matrix_v_cnt, data_combination,
    input  w_load_start, w_load_valid, w_load_data,
    output w_load_ready, coef_loaded, frame_drop,
    output conv_vsync, conv_href, conv_h_cnt, conv_v_cnt, conv_data
  );
endinterface

// File: rtl/conv3x3_relu.sv
// ---------------------------------------------------------------------------
// conv3x3_relu
// Fixed-point 3x3 convolution with bias, rounding, saturation and optional
// ReLU. Four register stages: products, row partial sums, total + bias,
// round/saturate/ReLU. One window per cycle, no back-pressure.
// Coefficients (k11..k33 then bias) arrive over a word channel, are staged in
// shadow registers and swap into the active set only once all ten words land.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : conv3x3_relu_if slave modport (window in, coefficients, results)
// ---------------------------------------------------------------------------
module conv3x3_relu #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int RELU_EN    = 1
) (
  input logic           clk,
  input logic           rst_n,
  conv3x3_relu_if.slave bus
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = PW + 2;
  localparam int TW = PW + 4;

  localparam logic signed [TW-1:0] RND     = TW'(2 ** (FRAC_BITS - 1));
  localparam logic signed [TW-1:0] SAT_MAX = {{(TW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [TW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_EMPTY,
    S_LOAD,
    S_READY
  } state_t;

  state_t state_q, state_d;
  logic   load_ready;
  logic   start_ok;
  logic   word_take;
  logic   coef_ok;
  logic   frame_drop_q;
  logic [3:0] word_cnt;

  logic signed [DATA_WIDTH-1:0] k_shadow [9];
  logic signed [DATA_WIDTH-1:0] k_act    [9];
  logic signed [DATA_WIDTH-1:0] bias_act;
  logic signed [DATA_WIDTH-1:0] pix      [9];

  logic signed [PW-1:0] prod [9];
  logic signed [SW-1:0] psum [3];
  logic signed [TW-1:0] total;
  logic signed [TW-1:0] bias_term;
  logic signed [TW-1:0] shifted;
  logic signed [DATA_WIDTH-1:0] res;
  logic signed [DATA_WIDTH-1:0] conv_data_q;

  logic [3:0] vld_pipe;
  logic [3:0] vs_pipe;
  logic [6:0] h_pipe [4];
  logic [6:0] v_pipe [4];

  // A load request is honoured only between frames so a frame never sees
  // a coefficient swap.
  assign start_ok  = bus.w_load_start & ~bus.matrix_vsync;
  assign word_take = load_ready & bus.w_load_valid & ~start_ok;
  assign coef_ok   = (state_q == S_READY);

  assign bus.w_load_ready = load_ready;
  assign bus.coef_loaded  = coef_ok;
  assign bus.frame_drop   = frame_drop_q;
  assign bus.conv_href    = vld_pipe[3];
  assign bus.conv_vsync   = vs_pipe[3];
  assign bus.conv_h_cnt   = h_pipe[3];
  assign bus.conv_v_cnt   = v_pipe[3];
  assign bus.conv_data    = conv_data_q;

  // Coefficient-set FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // Next-state logic; a restart while loading simply stays in S_LOAD and
  // the word counter rewinds.
  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    unique case (state_q)
      S_EMPTY, S_READY: begin
        if (start_ok) state_d = S_LOAD;
      end
      S_LOAD: begin
        load_ready = 1'b1;
        if (!start_ok && bus.w_load_valid && word_cnt == 4'd9) state_d = S_READY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Word counter, shadow kernel and active set. The bias word completes the
  // set and promotes the shadow kernel in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
      bias_act <= '0;
      for (int i = 0; i < 9; i++) begin
        k_shadow[i] <= '0;
        k_act[i]    <= '0;
      end
    end else if (start_ok) begin
      word_cnt <= '0;
    end else if (word_take) begin
      if (word_cnt == 4'd9) begin
        word_cnt <= '0;
        bias_act <= bus.w_load_data;
        for (int i = 0; i < 9; i++) k_act[i] <= k_shadow[i];
      end else begin
        k_shadow[word_cnt] <= bus.w_load_data;
        word_cnt           <= word_cnt + 4'd1;
      end
    end
  end

  // Sticky drop flag: a new window arriving without a kernel outranks a
  // simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                frame_drop_q <= 1'b0;
    else if (bus.matrix_href && !coef_ok)      frame_drop_q <= 1'b1;
    else if (start_ok)                         frame_drop_q <= 1'b0;
  end

  // Unpack the window; p11 sits in the most significant slot.
  always_comb begin
    for (int i = 0; i < 9; i++)
      pix[i] = bus.data_combination[(8-i)*DATA_WIDTH +: DATA_WIDTH];
  end

  assign bias_term = TW'(bias_act) <<< FRAC_BITS;

  // Sideband delay lines; a slot is valid only if a kernel was in place
  // when its window arrived.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      vs_pipe  <= '0;
      for (int i = 0; i < 4; i++) begin
        h_pipe[i] <= '0;
        v_pipe[i] <= '0;
      end
    end else begin
      vld_pipe  <= {vld_pipe[2:0], bus.matrix_href & coef_ok};
      vs_pipe   <= {vs_pipe[2:0], bus.matrix_vsync};
      h_pipe[0] <= bus.matrix_h_cnt;
      v_pipe[0] <= bus.matrix_v_cnt;
      for (int i = 1; i < 4; i++) begin
        h_pipe[i] <= h_pipe[i-1];
        v_pipe[i] <= v_pipe[i-1];
      end
    end
  end

  // Arithmetic stages 1-3: products, row sums, total plus aligned bias.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) prod[i] <= '0;
      for (int j = 0; j < 3; j++) psum[j] <= '0;
      total <= '0;
    end else begin
      for (int i = 0; i < 9; i++) prod[i] <= PW'(pix[i]) * PW'(k_act[i]);
      for (int j = 0; j < 3; j++)
        psum[j] <= SW'(prod[3*j]) + SW'(prod[3*j+1]) + SW'(prod[3*j+2]);
      total <= TW'(psum[0]) + TW'(psum[1]) + TW'(psum[2]) + bias_term;
    end
  end

  // Round half up, drop fraction, saturate, then optional ReLU.
  always_comb begin
    shifted = (total + RND) >>> FRAC_BITS;
    res     = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX)      res = OUT_MAX;
    else if (shifted < SAT_MIN) res = OUT_MIN;
    if (RELU_EN != 0 && res[DATA_WIDTH-1]) res = '0;
  end

  // Output register; empty slots are forced to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           conv_data_q <= '0;
    else if (vld_pipe[2]) conv_data_q <= res;
    else                  conv_data_q <= '0;
  end

endmodule

// File: doc/conv3x3_relu.md
CONV3X3_RELU -- requirements
Module: conv3x3_relu

Interface
REQ-001 Parameter DATA_WIDTH, default 16; width of each pixel, weight, bias and result, signed two's complement.
REQ-002 Parameter FRAC_BITS, default 8; fractional bits of pixel, weight, bias and result (Q7.8 at defaults).
REQ-003 Parameter RELU_EN, default 1; 1 = clamp negative results to zero, 0 = pass signed result.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 matrix_vsync  input  1  frame-active from window generator.
REQ-007 matrix_href  input  1  window valid this cycle.
REQ-008 matrix_h_cnt  input  7  window column index.
REQ-009 matrix_v_cnt  input  7  window row index.
REQ-010 data_combination  input  9*DATA_WIDTH  3x3 window; p11 in MSBs, then p12, p13, p21 ... p33 in LSBs.
REQ-011 w_load_start  input  1  single-cycle pulse requesting a coefficient load.
REQ-012 w_load_valid  input  1  coefficient word valid.
REQ-013 w_load_data  input  DATA_WIDTH  coefficient word: k11..k33 in row-major order, then bias.
REQ-014 w_load_ready  output  1  block accepts w_load_data this cycle.
REQ-015 coef_loaded  output  1  complete coefficient set held.
REQ-016 frame_drop  output  1  sticky: window(s) arrived while coef_loaded=0.
REQ-017 conv_vsync, conv_href  output  1 each  matrix_vsync/matrix_href delayed by pipeline latency.
REQ-018 conv_h_cnt, conv_v_cnt  output  7 each  matrix_h_cnt/matrix_v_cnt delayed by pipeline latency.
REQ-019 conv_data  output  DATA_WIDTH  convolution result.

Function
REQ-020 FSM states: S_EMPTY (no valid set), S_LOAD (accepting words), S_READY (set valid).
REQ-021 S_EMPTY or S_READY -> S_LOAD on w_load_start while matrix_vsync=0; w_load_start while matrix_vsync=1 is ignored.
REQ-022 In S_LOAD, w_load_ready=1; a word is taken on w_load_valid&w_load_ready; 4-bit word counter 0..9.
REQ-023 Word 9 (bias) accepted -> S_READY, coef_loaded=1 next cycle; counter clears.
REQ-024 Entering S_LOAD clears coef_loaded; the new set is staged in shadow registers and replaces the active set only on completion.
REQ-025 w_load_start during S_LOAD restarts the counter at 0.
REQ-026 w_load_ready=0 in S_EMPTY and S_READY; w_load_valid there is ignored.
REQ-027 Stage 1: nine signed products p_ij*k_ij, 2*DATA_WIDTH bits each, registered.
REQ-028 Stage 2: partial sums of products {1-3},{4-6},{7-9}, registered, 2*DATA_WIDTH+2 bits.
REQ-029 Stage 3: total = sum of partials + (bias sign-extended, shifted left FRAC_BITS), 2*DATA_WIDTH+4 bits, registered.
REQ-030 Stage 4: add 2^(FRAC_BITS-1), arithmetic shift right FRAC_BITS, saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], apply ReLU if RELU_EN, register to conv_data.
REQ-031 Latency: input cycle N -> conv_* cycle N+4; one result per cycle, no back-pressure, no bubbles.
REQ-032 conv_href=1 only for windows whose matrix_href=1 arrived with coef_loaded=1; otherwise conv_href=0 for that slot.
REQ-033 matrix_href=1 with coef_loaded=0 sets frame_drop; cleared only by reset or by w_load_start being accepted.
REQ-034 conv_data is zero in every cycle conv_href=0.
REQ-035 Coefficient set in use is constant for a whole frame (guaranteed by REQ-021).

Reset
REQ-036 rst_n=0 asynchronously: FSM=S_EMPTY, all pipeline and delay registers, coefficients, bias, counter = 0; all outputs = 0.
REQ-037 Reset mid-load or mid-frame discards partial set and in-flight results; first output valid only after a full reload.

Verification
REQ-038 Load k=0x0100 x9, bias=0; window all 0x0100, href pulse at cycle N -> conv_href=1, conv_data=0x0900 at N+4.
REQ-039 Load k11..k33=0x0100, bias=0xFF00 (-1.0); window all 0x0080 -> conv_data=0x0380 (4.5-1.0).
REQ-040 k=0x7FFF x9, window all 0x7FFF -> conv_data=0x7FFF (saturation); same with window 0x8000, RELU_EN=0 -> 0x8000, RELU_EN=1 -> 0x0000.
REQ-041 Window stream with matrix_href high before any load -> conv_href=0 throughout, frame_drop=1; w_load_start -> frame_drop=0.
REQ-042 w_load_start while matrix_vsync=1 -> w_load_ready stays 0, results unchanged; 64-window row back-to-back -> 64 consecutive conv_href cycles, conv_h_cnt 0..63 delayed by 4.
REQ-043 Assert rst_n=0 after 5 of 10 load words -> all outputs 0, coef_loaded=0; full reload then restores correct results.
